mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch and the load/store path.
- Sequences one memory transaction at a time and returns read data to the winning requester.
- Drives the fetch unit's busy input, so PC advance is held until the instruction word is available.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  jump/branch redirect; discard in-flight fetch result
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  instruction word
- if_busy  out  1  to fetch unit busy; = if_req & ~if_valid
- d_req  in  1  load/store request; held until d_valid
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  3  access_size encoding, passed through
- d_valid  out  1  one-cycle pulse; load data / store done
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_size  out  3  access size (fetch always 3'd4 = word)
- mem_ready  in  1  one-cycle completion; mem_rdata valid same cycle
- mem_rdata  in  DATA_W  read data

Behaviour:
- FSM states: IDLE, FETCH, DATA.
- Reset (rst_n=0 at a clk edge; valid mid-transaction):
  - state=IDLE; all mem_* outputs 0; if_valid=d_valid=0; rdata regs 0; starve_cnt=0; flush_pend=0.
  - Any in-flight memory access is abandoned; no valid pulse is issued.
- IDLE arbitration, on each edge:
  - Effective requests: if_req & ~if_valid, d_req & ~d_valid. The current-cycle valid masks re-grant of a request not yet dropped.
  - Only data pending -> DATA.
  - Only fetch pending -> FETCH.
  - Both pending: starve_cnt==STARVE_MAX -> FETCH; else -> DATA.
- Granting latches mem_addr/we/wdata/size and sets mem_req=1 in the next cycle. Request-to-mem_req latency is 1 cycle.
- mem_* outputs stay stable while mem_req=1 and mem_ready=0.
- On mem_ready in FETCH or DATA:
  - Register mem_rdata into the requester's rdata.
  - Pulse that requester's valid in the next cycle.
  - Clear mem_req and return to IDLE.
- Minimum access is 3 cycles: grant, ready, valid. Back-to-back grants have one IDLE cycle between them.
- mem_ready outside FETCH/DATA is ignored.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on a DATA grant with fetch pending.
  - Cleared on any FETCH grant.
  - Cleared on a DATA grant with no fetch pending.
- Flush:
  - if_flush in state FETCH sets flush_pend. The transaction still completes; if_valid is suppressed and if_rdata is not updated.
  - flush_pend clears on that mem_ready.
  - if_flush in IDLE or DATA has no effect.
  - if_flush coincident with mem_ready in FETCH suppresses that completion.
- Stores return d_valid; d_rdata is unchanged.
- No combinational path from mem_ready to mem_req. if_busy is the only combinational output.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE/ST_FETCH/ST_DATA.
  - access_size constants SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4, shared with fetch and load/store units.
- One natural sub-module: starve_counter (saturating counter with clear/increment/limit flag).

Test Plan:
- Single fetch: if_req=1, addr 0x8002_0000, mem_ready 2 cycles after mem_req with rdata 0x2408_0005 -> mem_size=4, mem_we=0, if_valid one cycle, if_rdata=0x2408_0005, if_busy=1 until that cycle.
- Simultaneous if_req and d_req (load 0x1000_0010) -> DATA granted first, d_valid, then IDLE, then FETCH; no re-grant to data while d_valid is high.
- Starvation: d_req held continuously with new requests, if_req=1, STARVE_MAX=4 -> 4 data grants, 5th grant is FETCH, starve_cnt returns to 0.
- Flush: if_flush pulsed during FETCH before mem_ready -> mem transaction completes, no if_valid, if_rdata unchanged, next if_req is served normally.
- Store: d_we=1, d_size=1, wdata 0x0000_00AB -> mem_we=1, mem_size=1, mem_wdata stable until mem_ready, d_valid pulses, d_rdata unchanged.
- Reset mid-access: rst_n=0 while mem_req=1 awaiting ready -> next cycle mem_req=0, state IDLE, no valid pulses; a late mem_ready is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared constants for the unified memory port arbiter.
//                Holds the arbiter state encoding and the access_size
//                encoding that the fetch and load/store units also use.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter state encoding
    localparam int         STATE_W  = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    // access_size encoding, common to fetch, load/store and memory
    localparam logic [2:0] SZ_BYTE  = 3'd1;
    localparam logic [2:0] SZ_HALF  = 3'd2;
    localparam logic [2:0] SZ_WORD  = 3'd4;

    // Starvation counter width; covers STARVE_MAX up to 15
    localparam int         STARVE_CNT_W = 4;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_starve_counter
//  Description : Saturating counter of consecutive data grants that were
//                made while a fetch was waiting. Raises o_at_limit once the
//                count reaches STARVE_MAX so the arbiter lets fetch win.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] r_cnt;
    logic                    w_at_limit;

    assign w_at_limit = (r_cnt == C_LIMIT);
    assign o_at_limit = w_at_limit;

    // Count data wins over a waiting fetch; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : mem_port_arbiter_starve_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between instruction fetch and the
//                load/store path. One transaction at a time; data requests
//                have priority, bounded by a starvation counter so fetch
//                always makes progress. Fetch results can be discarded by a
//                redirect (if_flush) while the access is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_busy,
    // load/store side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_size,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [STATE_W-1:0] r_state;
    logic               r_flush_pend;
    logic               r_if_valid;
    logic               r_d_valid;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [2:0]         r_mem_size;

    logic w_idle;
    logic w_if_pend;
    logic w_d_pend;
    logic w_grant_d;
    logic w_grant_f;
    logic w_starve_limit;
    logic w_starve_clr;
    logic w_starve_inc;

    // A requester whose valid is high this cycle has been served already;
    // its request is still up only because it has not seen valid yet.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_if_pend = if_req & ~r_if_valid;
    assign w_d_pend  = d_req  & ~r_d_valid;

    // Data wins unless fetch has waited out STARVE_MAX data grants
    assign w_grant_d = w_idle & w_d_pend & (~w_if_pend | ~w_starve_limit);
    assign w_grant_f = w_idle & w_if_pend & ~w_grant_d;

    assign w_starve_inc = w_grant_d &  w_if_pend;
    assign w_starve_clr = w_grant_f | (w_grant_d & ~w_if_pend);

    mem_port_arbiter_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_starve_clr),
        .i_inc      (w_starve_inc),
        .o_at_limit (w_starve_limit)
    );

    // Arbitration FSM: grant in IDLE, hold the access, complete on mem_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_size   <= 3'd0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_DATA;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_size  <= d_size;
                    end else if (w_grant_f) begin
                        r_state     <= ST_FETCH;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_size  <= SZ_WORD;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state      <= ST_IDLE;
                        r_mem_req    <= 1'b0;
                        r_flush_pend <= 1'b0;
                        // A redirect seen at any point of the access, including
                        // the completing cycle, discards the instruction word
                        if (!(r_flush_pend || if_flush)) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end else if (if_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (mem_ready) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_d_valid <= 1'b1;
                        // Stores complete without touching the load data
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign if_busy   = w_if_pend;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;

endmodule : mem_port_arbiter
`default_nettype wire
